// File: rtl/prog_mem_loader.sv
// prog_mem_loader
//   Boot-time program memory loader shared by N_CORES cores. A host opens a
//   load session with ld_start, streams words in with a valid/ready handshake,
//   and ends the session with ld_last. After a fixed release delay the cores
//   come out of reset and fetch from their own synchronous read ports.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (control state only)
//   ld_start   one-cycle pulse opening a load session (HOLD or RUN only)
//   ld_base    first write address, sampled with ld_start
//   ld_valid   ld_data holds a word to store
//   ld_ready   block accepts a word this cycle (LOAD only)
//   ld_data    instruction word to store
//   ld_last    marks the final word of the session
//   ld_err     sticky: a word of the current/last session was dropped
//   ld_count   words stored in the current/last session
//   busy       high in LOAD or RELEASE
//   core_addr  per-core fetch address, core i at [i*ADDR_W +: ADDR_W]
//   core_data  per-core fetched word (latency 1), zero unless RUN
//   core_reset per-core reset, active-high, released only in RUN
module prog_mem_loader #(
    parameter int DATA_W   = 14,
    parameter int ADDR_W   = 10,
    parameter int N_CORES  = 2,
    parameter int REL_DLY  = 4,
    parameter int BOOT_RUN = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ld_start,
    input  logic [ADDR_W-1:0]           ld_base,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [DATA_W-1:0]           ld_data,
    input  logic                        ld_last,
    output logic                        ld_err,
    output logic [ADDR_W:0]             ld_count,
    output logic                        busy,
    input  logic [N_CORES*ADDR_W-1:0]   core_addr,
    output logic [N_CORES*DATA_W-1:0]   core_data,
    output logic [N_CORES-1:0]          core_reset
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {HOLD, LOAD, RELEASE, RUN} state_t;
    localparam state_t RST_STATE = (BOOT_RUN != 0) ? RUN : HOLD;

    state_t                 state;
    state_t                 nextState;
    // One extra bit so a pointer that has run past the top of memory is
    // distinguishable from a wrap back to address 0.
    logic [ADDR_W:0]        wptr;
    logic [7:0]             relCnt;
    logic                   startReq;
    logic                   accept;
    logic                   wrEn;
    logic                   rdVld_p1;

    logic [DATA_W-1:0]      mem [DEPTH];
    logic [DATA_W-1:0]      rdData_p1 [N_CORES];

    // ld_start only opens a session from an idle or running block.
    assign startReq   = ld_start && ((state == HOLD) || (state == RUN));
    assign accept     = ld_valid && (state == LOAD);
    assign wrEn       = accept && !wptr[ADDR_W];

    assign ld_ready   = (state == LOAD);
    assign busy       = (state == LOAD) || (state == RELEASE);
    assign core_reset = {N_CORES{state != RUN}};

    always_comb begin
        nextState = state;
        case (state)
            HOLD:    if (startReq) nextState = LOAD;
            LOAD:    if (accept && ld_last) nextState = RELEASE;
            // Leaving on the count of 1 keeps RELEASE exactly REL_DLY cycles long.
            RELEASE: if (relCnt <= 8'd1) nextState = RUN;
            RUN:     if (startReq) nextState = LOAD;
            default: nextState = HOLD;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RST_STATE;
            wptr     <= '0;
            relCnt   <= '0;
            ld_count <= '0;
            ld_err   <= 1'b0;
            rdVld_p1 <= 1'b0;
        end else begin
            state    <= nextState;
            rdVld_p1 <= 1'b1;
            if (startReq) begin
                wptr     <= {1'b0, ld_base};
                ld_count <= '0;
                ld_err   <= 1'b0;
            end else if (accept) begin
                if (wptr[ADDR_W]) begin
                    ld_err <= 1'b1;
                end else begin
                    wptr     <= wptr + 1'b1;
                    ld_count <= ld_count + 1'b1;
                end
                if (ld_last) relCnt <= 8'(REL_DLY);
            end else if ((state == RELEASE) && (relCnt != 8'd0)) begin
                relCnt <= relCnt - 8'd1;
            end
        end
    end

    // Storage and read stage p0 -> p1; contents are never reset
    always_ff @(posedge clk) begin
        if (wrEn) mem[wptr[ADDR_W-1:0]] <= ld_data;
        for (int i = 0; i < N_CORES; i++) begin
            rdData_p1[i] <= mem[core_addr[i*ADDR_W +: ADDR_W]];
        end
    end

    // Output stage p1: cores see NOPs unless running. rdVld_p1 masks the
    // read register until a clock edge has loaded it after reset.
    always_comb begin
        core_data = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (rdVld_p1 && (state == RUN)) core_data[i*DATA_W +: DATA_W] = rdData_p1[i];
        end
    end

endmodule
